// File: rtl/spimaster_wide_pkg.sv
// Shared types and reset levels for the wide SPI master engine.
package spimaster_wide_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    XFER     = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } mode_t;

  localparam logic MOSI_RST = 1'b1;
  localparam logic SCLK_RST = 1'b0;

endpackage

// File: rtl/spimaster_wide_sclk_gen.sv
// SCLK timing for one word: half-period divider, sclk toggling and edge counting.
// Strobes are combinational and mark the cycle whose closing clock edge moves sclk.
module spi_sclk_gen
  import spimaster_wide_pkg::*;
#(
  parameter int DIV_W  = 9,
  parameter int EDGE_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              run,
  input  logic [DIV_W-1:0]  start_div,
  input  logic [DIV_W-1:0]  div,
  input  logic              start_cpol,
  input  logic              cpol,
  input  logic [EDGE_W-1:0] edge_total,
  output logic              sclk,
  output logic              lead_edge,
  output logic              trail_edge,
  output logic              last_edge,
  output logic              done
);

  logic [DIV_W-1:0]  cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic              tick;
  logic              more;

  assign tick       = run && (cnt == '0);
  assign more       = (edge_cnt != edge_total);
  assign lead_edge  = tick && more && !edge_cnt[0];
  assign trail_edge = tick && more && edge_cnt[0];
  assign last_edge  = trail_edge && ((edge_cnt + EDGE_W'(1)) == edge_total);
  // After the final edge one more idle-level half-period elapses before done.
  assign done       = tick && !more;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      edge_cnt <= '0;
      sclk     <= SCLK_RST;
    end else if (start) begin
      cnt      <= start_div;
      edge_cnt <= '0;
      sclk     <= start_cpol;
    end else if (run) begin
      if (cnt == '0) begin
        cnt <= div;
        if (more) begin
          edge_cnt <= edge_cnt + EDGE_W'(1);
          sclk     <= ~sclk;
        end else begin
          sclk <= cpol;
        end
      end else begin
        cnt <= cnt - DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/spimaster_wide.sv
// Parametrised SPI master shift engine: all four modes, runtime word length, MSB/LSB first.
// Optional internal loopback of mosi into the receive path under SPIMASTER_WIDE_LOOPBACK_EN.
module spimaster_wide
  import spimaster_wide_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 9,
  parameter int LEN_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  divider,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [LEN_W-1:0]  word_len,
  input  logic              xfer_start,
  output logic              busy,
  output logic              xfer_complete,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
`ifdef SPIMASTER_WIDE_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic              miso,
  output logic              mosi,
  output logic              sclk
);

  localparam int EDGE_W = LEN_W + 2;

  state_t             state;
  mode_t              mode_q;
  logic [LEN_W-1:0]   len_q;
  logic [DIV_W-1:0]   div_q;
  logic [DATA_W-1:0]  tx_q;
  logic [DATA_W-1:0]  rx_sh;
  logic [LEN_W-1:0]   pos;
  logic [EDGE_W-1:0]  edge_total;
  logic               start;
  logic               run;
  logic               lead_edge;
  logic               trail_edge;
  logic               last_edge;
  logic               done;
  logic               sample_en;
  logic               shift_en;
  logic               in_bit;

  function automatic logic pick_bit(input logic [DATA_W-1:0] w, input logic [LEN_W-1:0] len,
                                    input logic lsb, input logic [LEN_W-1:0] p);
    logic [LEN_W-1:0] idx;
    idx = lsb ? p : (len - p);
    return w[idx];
  endfunction

  // MSB-first grows upward from bit 0; LSB-first enters at bit len and drifts down.
  function automatic logic [DATA_W-1:0] rx_insert(input logic [DATA_W-1:0] r, input logic b,
                                                  input logic [LEN_W-1:0] len, input logic lsb);
    logic [DATA_W-1:0] res;
    if (lsb) begin
      res      = r >> 1;
      res[len] = b;
    end else begin
      res = {r[DATA_W-2:0], b};
    end
    return res;
  endfunction

  assign start      = (state == IDLE) && xfer_start;
  assign run        = (state == XFER);
  assign edge_total = (EDGE_W'(len_q) + EDGE_W'(1)) << 1;
  assign sample_en  = mode_q.cpha ? trail_edge : lead_edge;
  assign shift_en   = mode_q.cpha ? lead_edge : (trail_edge && !last_edge);

`ifdef SPIMASTER_WIDE_LOOPBACK_EN
  logic lb_q;
  assign in_bit = lb_q ? mosi : miso;
`else
  assign in_bit = miso;
`endif

  spi_sclk_gen #(
    .DIV_W  (DIV_W),
    .EDGE_W (EDGE_W)
  ) u_sclk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .run        (run),
    .start_div  (divider),
    .div        (div_q),
    .start_cpol (cpol),
    .cpol       (mode_q.cpol),
    .edge_total (edge_total),
    .sclk       (sclk),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .last_edge  (last_edge),
    .done       (done)
  );

  always_ff @(posedge clk) begin
    if (start) begin
      tx_q  <= tx_data;
      rx_sh <= '0;
    end else if (sample_en) begin
      rx_sh <= rx_insert(rx_sh, in_bit, len_q, mode_q.lsb_first);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      xfer_complete <= 1'b0;
      mosi          <= MOSI_RST;
      rx_data       <= '0;
      mode_q        <= '0;
      len_q         <= '0;
      div_q         <= '0;
      pos           <= '0;
`ifdef SPIMASTER_WIDE_LOOPBACK_EN
      lb_q          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (xfer_start) begin
            mode_q <= {cpol, cpha, lsb_first};
            len_q  <= word_len;
            div_q  <= divider;
            busy   <= 1'b1;
            state  <= XFER;
`ifdef SPIMASTER_WIDE_LOOPBACK_EN
            lb_q   <= loopback;
`endif
            // cpha=0 presents the first bit before the first edge.
            if (!cpha) begin
              mosi <= pick_bit(tx_data, word_len, lsb_first, '0);
              pos  <= LEN_W'(1);
            end else begin
              mosi <= MOSI_RST;
              pos  <= '0;
            end
          end
        end
        XFER: begin
          if (shift_en) begin
            mosi <= pick_bit(tx_q, len_q, mode_q.lsb_first, pos);
            pos  <= pos + LEN_W'(1);
          end
          if (done) begin
            state         <= COMPLETE;
            xfer_complete <= 1'b1;
            rx_data       <= rx_sh;
            mosi          <= MOSI_RST;
          end
        end
        COMPLETE: begin
          xfer_complete <= 1'b0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spimaster_wide.sv
// Randomised bench for spimaster_wide (DATA_W=16) with an edge-counting SPI slave model.
module tb_spimaster_wide;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  divider;
  logic        cpol, cpha, lsb_first;
  logic [3:0]  word_len;
  logic        xfer_start;
  logic        busy, xfer_complete;
  logic [15:0] tx_data, rx_data;
  logic        loopback;
  logic        miso, mosi, sclk;

  int checks   = 0;
  int failures = 0;
  logic [15:0] last_rx = '0;

`ifdef SPIMASTER_WIDE_LOOPBACK_EN
  localparam bit HAS_LB = 1'b1;
`else
  localparam bit HAS_LB = 1'b0;
`endif

  always #5 clk = ~clk;

  spimaster_wide #(.DATA_W(16), .DIV_W(9)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .divider       (divider),
    .cpol          (cpol),
    .cpha          (cpha),
    .lsb_first     (lsb_first),
    .word_len      (word_len),
    .xfer_start    (xfer_start),
    .busy          (busy),
    .xfer_complete (xfer_complete),
    .tx_data       (tx_data),
    .rx_data       (rx_data),
`ifdef SPIMASTER_WIDE_LOOPBACK_EN
    .loopback      (loopback),
`endif
    .miso          (miso),
    .mosi          (mosi),
    .sclk          (sclk)
  );

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Starts in an IDLE cycle at a negedge; returns at the negedge of the following IDLE cycle.
  task automatic run_xfer(input logic [15:0] tx, input int n, input int dv, input logic cp,
                          input logic cph, input logic lsb, input logic [15:0] sw,
                          input logic lb, input logic hold);
    int d, t, e, k, i, j, seen, got_c, exp_c, sbad, mbad, bbad, hbad;
    logic prev, exp_s, cm_mosi;
    logic [15:0] exp_rx, rx_obs, mask;
    d     = dv + 1;
    exp_c = 1 + (2 * n + 3) * d;
    mask  = 16'((32'd1 << (n + 1)) - 1);
    exp_rx = (lb ? tx : sw) & mask;
    divider = 9'(dv); cpol = cp; cpha = cph; lsb_first = lsb; word_len = 4'(n);
    tx_data = tx; loopback = lb; xfer_start = 1'b1;
    miso = sw[lsb ? 0 : n];
    @(posedge clk);
    t = 0; seen = 0; got_c = 0; sbad = 0; mbad = 0; bbad = 0; hbad = 0;
    prev = 1'b0; rx_obs = '0; cm_mosi = 1'b0;
    while (got_c == 0 && t < exp_c + 20) begin
      @(negedge clk);
      t++;
      if (t == 1) begin
        if (!hold) xfer_start = 1'b0;
        divider = 9'($urandom); cpol = 1'($urandom); cpha = 1'($urandom);
        lsb_first = 1'($urandom); word_len = 4'($urandom); tx_data = 16'($urandom);
        loopback = 1'($urandom);
      end
      if (!hold && t == 3) xfer_start = 1'b1;
      if (!hold && t == 4) xfer_start = 1'b0;
      e = (t - 1) / d;
      if (e > 2 * n + 2) e = 2 * n + 2;
      exp_s = cp ^ e[0];
      if (sclk !== exp_s) sbad++;
      if (busy !== 1'b1) bbad++;
      if (t >= 2 && sclk !== prev) seen++;
      prev = sclk;
      if (t % d == 0) begin
        k = t / d;
        i = -1;
        if (!cph && k % 2 == 1 && k <= 2 * n + 1) i = (k - 1) / 2;
        if (cph && k % 2 == 0 && k >= 2 && k <= 2 * n + 2) i = k / 2 - 1;
        if (i >= 0 && mosi !== tx[lsb ? i : n - i]) mbad++;
      end
      if (xfer_complete === 1'b1) begin
        got_c   = t;
        rx_obs  = rx_data;
        cm_mosi = mosi;
      end else if (rx_data !== last_rx) begin
        hbad++;
      end
      j = cph ? ((seen == 0) ? 0 : (seen - 1) / 2) : seen / 2;
      if (j > n) j = n;
      miso = sw[lsb ? j : n - j];
    end
    chk_val("complete_cycle", got_c, exp_c);
    chk_val("rx_data", rx_obs, exp_rx);
    chk_val("sclk_wave_errs", sbad, 0);
    chk_val("mosi_bit_errs", mbad, 0);
    chk_val("busy_errs", bbad, 0);
    chk_val("rx_hold_errs", hbad, 0);
    chk_val("complete_mosi", cm_mosi, 1);
    last_rx = exp_rx;
    @(negedge clk);
    chk_val("idle_after", {busy, xfer_complete, mosi, sclk}, {1'b0, 1'b0, 1'b1, cp});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt, seen;
    logic prev;
    rst_n = 1'b0; xfer_start = 1'b0; divider = '0; cpol = 1'b0; cpha = 1'b0;
    lsb_first = 1'b0; word_len = '0; tx_data = '0; loopback = 1'b0; miso = 1'b0;
    repeat (3) @(negedge clk);
    chk_val("reset_pins", {sclk, mosi, busy, xfer_complete}, 4'b0100);
    chk_val("reset_rx", rx_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_xfer(16'h00A5, 7, 0, 1'b0, 1'b0, 1'b0, 16'h003C, 1'b0, 1'b0);
    for (int m = 1; m < 4; m++)
      run_xfer(16'h0081, 7, 3, m[1], m[0], 1'b0, 16'($urandom), 1'b0, 1'b0);
    run_xfer(16'hFABC, 11, 1, 1'b0, 1'b0, 1'b1, 16'($urandom), 1'b0, 1'b0);
    run_xfer(16'h0F0F, 15, 0, 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    run_xfer(16'h0001, 0, 2, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);

    run_xfer(16'h00C3, 7, 0, 1'b0, 1'b0, 1'b0, 16'h0055, 1'b0, 1'b1);
    run_xfer(16'h003C, 7, 0, 1'b1, 1'b0, 1'b1, 16'h00AA, 1'b0, 1'b1);
    run_xfer(16'h0099, 7, 1, 1'b0, 1'b1, 1'b0, 16'h0066, 1'b0, 1'b0);

    for (int r = 0; r < 20; r++)
      run_xfer(16'($urandom), $urandom_range(0, 15), $urandom_range(0, 4), 1'($urandom),
               1'($urandom), 1'($urandom), 16'($urandom), HAS_LB & 1'($urandom),
               ($urandom_range(0, 3) == 0));

    // Abort after the fifth sclk edge of a mode-2 word.
    divider = 9'd1; cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; word_len = 4'd7;
    tx_data = 16'h00F0; loopback = 1'b0; xfer_start = 1'b1; miso = 1'b1;
    @(posedge clk);
    @(negedge clk);
    xfer_start = 1'b0;
    prev = sclk; seen = 0; cnt = 0;
    while (seen < 5 && cnt < 400) begin
      @(negedge clk);
      cnt++;
      if (sclk !== prev) seen++;
      prev = sclk;
    end
    chk_val("reach_edge5", seen, 5);
    rst_n = 1'b0;
    #1;
    chk_val("abort_pins", {sclk, mosi, busy, xfer_complete}, 4'b0100);
    chk_val("abort_rx", rx_data, 0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (xfer_complete !== 1'b0) cnt++;
    end
    chk_val("abort_no_complete", cnt, 0);
    rst_n = 1'b1;
    last_rx = '0;
    @(negedge clk);
    run_xfer(16'h0137, 9, 2, 1'b0, 1'b1, 1'b1, 16'h02C5, 1'b0, 1'b0);

    if (HAS_LB)
      run_xfer(16'h005A, 7, 1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

    xfer_start = 1'b0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
